// File: rtl/spi_pkg.sv
// Shared definitions for the APB SPI master: register offsets, CTRL bit fields, FSM states.
package spi_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_CLKDIV = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_TXDATA = 8'h0C;
  localparam logic [7:0] ADDR_RXDATA = 8'h10;
  localparam logic [7:0] ADDR_IRQEN  = 8'h14;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_CPOL  = 1;
  localparam int CTRL_CPHA  = 2;
  localparam int CTRL_LSBFE = 3;
  localparam int CTRL_SS_LO = 4;
  localparam int CTRL_W     = 7;

  localparam int ST_RXOVF   = 5;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; push on full is dropped unless a pop
// happens in the same cycle, pop on empty is ignored.
module spi_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | pop_i);
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_master_fifo.sv
// APB SPI master with TX/RX FIFOs and back-to-back frames on a single clock.
// Optional irq output and IRQEN register when SPI_MASTER_FIFO_IRQ_EN is defined.
module spi_master_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SS     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
`ifdef SPI_MASTER_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int EW = $clog2(2*DATA_W + 1);

  state_e              state_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [15:0]         div_q, act_div_q, cnt_q;
  logic [EW-1:0]       edge_q;
  logic [DATA_W-1:0]   tx_q, rx_q;
  logic                rxovf_q, sclk_q, mosi_q, act_cpha_q, act_lsb_q;
  logic [NUM_SS-1:0]   ss_q;
  logic [31:0]         prdata_q, rd_data_d, rx_ext;
  logic                pslverr_q, rd_err_d, rd_pop_q;
  logic                setup, acc_wr, acc_rd, busy;
  logic                tx_push, tx_pop, tx_full, tx_empty;
  logic                rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0]   tx_rdata, rx_rdata;
  logic                half_done, trail_done, go_lead, drive_edge, last_edge, rx_ovf_set;
  logic                unused_pwdata;

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  // An out-of-range select leaves every slave deselected.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [2:0] sel);
    logic [NUM_SS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (sel == 3'(i)) r[i] = 1'b0;
    end
    return r;
  endfunction

  assign setup  = PSEL & ~PENABLE;
  assign acc_wr = PSEL & PENABLE & PWRITE;
  assign acc_rd = PSEL & PENABLE & ~PWRITE;
  assign busy   = (state_q != IDLE);

  assign tx_push = acc_wr & (PADDR == ADDR_TXDATA);
  assign rx_pop  = acc_rd & (PADDR == ADDR_RXDATA) & rd_pop_q;

  assign half_done  = (cnt_q == act_div_q);
  assign trail_done = (state_q == TRAIL) & half_done;
  assign go_lead    = ctrl_q[CTRL_EN] & ~tx_empty & ((state_q == IDLE) | trail_done);
  assign tx_pop     = go_lead;
  assign rx_push    = trail_done;
  assign rx_ovf_set = trail_done & rx_full & ~rx_pop;
  assign drive_edge = act_cpha_q ? ~edge_q[0] : edge_q[0];
  assign last_edge  = (edge_q == EW'(2*DATA_W - 1));
  assign unused_pwdata = ^PWDATA;

  spi_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(tx_push), .wdata_i(PWDATA[DATA_W-1:0]),
    .pop_i(tx_pop), .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty)
  );

  spi_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(rx_push), .wdata_i(rx_q),
    .pop_i(rx_pop), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty)
  );

`ifdef SPI_MASTER_FIFO_IRQ_EN
  logic [2:0] irqen_q;
  logic       irq_q;
  assign irq = irq_q;
`endif

  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    rx_ext    = '0;
    rx_ext[DATA_W-1:0] = rx_rdata;
    case (PADDR)
      ADDR_CTRL:   rd_data_d[CTRL_W-1:0] = ctrl_q;
      ADDR_CLKDIV: rd_data_d[15:0] = div_q;
      ADDR_STATUS: rd_data_d[5:0] = {rxovf_q, busy, rx_full, rx_empty, tx_full, tx_empty};
      ADDR_TXDATA: ;
      ADDR_RXDATA: if (!rx_empty) rd_data_d = rx_ext;
`ifdef SPI_MASTER_FIFO_IRQ_EN
      ADDR_IRQEN:  rd_data_d[2:0] = irqen_q;
`endif
      default:     rd_err_d = 1'b1;
    endcase
  end

  // APB register file: read data and error are captured in the setup phase.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      rd_pop_q  <= 1'b0;
      ctrl_q    <= '0;
      div_q     <= '0;
      rxovf_q   <= 1'b0;
`ifdef SPI_MASTER_FIFO_IRQ_EN
      irqen_q   <= '0;
      irq_q     <= 1'b0;
`endif
    end else begin
      prdata_q  <= (setup & ~PWRITE) ? rd_data_d : '0;
      pslverr_q <= setup ? rd_err_d : 1'b0;
      rd_pop_q  <= setup & ~PWRITE & (PADDR == ADDR_RXDATA) & ~rx_empty;
      if (acc_wr && PADDR == ADDR_CTRL)   ctrl_q <= PWDATA[CTRL_W-1:0];
      if (acc_wr && PADDR == ADDR_CLKDIV) div_q  <= PWDATA[15:0];
      if (rx_ovf_set) rxovf_q <= 1'b1;
      else if (acc_wr && PADDR == ADDR_STATUS && PWDATA[ST_RXOVF]) rxovf_q <= 1'b0;
`ifdef SPI_MASTER_FIFO_IRQ_EN
      if (acc_wr && PADDR == ADDR_IRQEN) irqen_q <= PWDATA[2:0];
      irq_q <= |(irqen_q & {rxovf_q, ~rx_empty, tx_empty});
`endif
    end
  end

  // Frame engine; CTRL/CLKDIV settings are latched when a frame enters LEAD.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= '1;
      act_cpha_q <= 1'b0;
      act_lsb_q  <= 1'b0;
      act_div_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
      if (go_lead) begin
        state_q    <= LEAD;
        cnt_q      <= '0;
        edge_q     <= '0;
        act_cpha_q <= ctrl_q[CTRL_CPHA];
        act_lsb_q  <= ctrl_q[CTRL_LSBFE];
        act_div_q  <= div_q;
        sclk_q     <= ctrl_q[CTRL_CPOL];
        ss_q       <= ss_decode(ctrl_q[CTRL_SS_LO +: 3]);
        if (ctrl_q[CTRL_CPHA]) begin
          tx_q <= tx_rdata;
        end else begin
          mosi_q <= out_bit(tx_rdata, ctrl_q[CTRL_LSBFE]);
          tx_q   <= shift_out(tx_rdata, ctrl_q[CTRL_LSBFE]);
        end
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q  <= '0;
            sclk_q <= ctrl_q[CTRL_CPOL];
            ss_q   <= '1;
          end
          LEAD: if (half_done) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
          SHIFT: if (half_done) begin
            cnt_q  <= '0;
            edge_q <= edge_q + 1'b1;
            sclk_q <= ~sclk_q;
            if (drive_edge) begin
              mosi_q <= out_bit(tx_q, act_lsb_q);
              tx_q   <= shift_out(tx_q, act_lsb_q);
            end else begin
              rx_q <= shift_in(rx_q, miso, act_lsb_q);
            end
            if (last_edge) state_q <= TRAIL;
          end
          TRAIL: if (half_done) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ss_q    <= '1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;
  assign PREADY  = 1'b1;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_q;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: register vector table plus frame-level sequences
// with miso looped back to mosi.
module tb_spi_master_fifo;

  localparam int NUM_SS = 4;

  logic              PCLK = 1'b0;
  logic              PRESET, PSEL, PENABLE, PWRITE;
  logic [7:0]        PADDR;
  logic [31:0]       PWDATA, PRDATA;
  logic              PREADY, PSLVERR, sclk, mosi, miso;
  logic [NUM_SS-1:0] ss_n;
`ifdef SPI_MASTER_FIFO_IRQ_EN
  logic              irq;
`endif

  int n_vec = 0;
  int n_bad = 0;

  assign miso = mosi;
  always #5 PCLK = ~PCLK;

  spi_master_fifo #(.DATA_W(8), .NUM_SS(NUM_SS), .FIFO_DEPTH(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
`ifdef SPI_MASTER_FIFO_IRQ_EN
    , .irq(irq)
`endif
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic e;
    apb_wr(a, d, e);
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    d = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_rd(a, d, e);
    check(name, d, exp);
  endtask

  task automatic wait_ss(input bit high, input int bound, input string what);
    int c = 0;
    while (((ss_n == 4'hF) != high) && c < bound) begin
      @(posedge PCLK); #1;
      c++;
    end
    n_vec++;
    if ((ss_n == 4'hF) != high) begin
      n_bad++;
      $display("FAIL %s: timeout, ss_n=%b wanted all-high=%0d", what, ss_n, high);
    end
  endtask

  // Records mosi at each sclk rising edge, first bit ending up most significant.
  task automatic capture(input int nbits, input int period, output logic [31:0] seq,
                         output int bad_per, output logic [3:0] ss_at, output logic timeout);
    int got = 0;
    int last = 0;
    int cyc = 0;
    logic prev;
    seq = '0; bad_per = 0; ss_at = '1;
    prev = sclk;
    while (got < nbits && cyc < 400) begin
      @(posedge PCLK); #1;
      cyc++;
      if (!prev && sclk) begin
        seq = {seq[30:0], mosi};
        if (got == 0) ss_at = ss_n;
        else if (cyc - last != period) bad_per++;
        last = cyc;
        got++;
      end
      prev = sclk;
    end
    timeout = (got < nbits);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, seq;
    logic        e, to;
    int          bp, rises, ssbad, c;
    logic [3:0]  ssat;
    logic        prev;

    vt[0]  = '{1'b0, 8'h08, 32'h0,         32'h0000_0005, 1'b0};
    vt[1]  = '{1'b0, 8'h00, 32'h0,         32'h0000_0000, 1'b0};
    vt[2]  = '{1'b0, 8'h04, 32'h0,         32'h0000_0000, 1'b0};
    vt[3]  = '{1'b0, 8'h10, 32'h0,         32'h0000_0000, 1'b0};
    vt[4]  = '{1'b0, 8'h20, 32'h0,         32'h0000_0000, 1'b1};
    vt[5]  = '{1'b0, 8'h14, 32'h0,         32'h0000_0000, 1'b1};
    vt[6]  = '{1'b1, 8'h00, 32'h0000_007E, 32'h0,         1'b0};
    vt[7]  = '{1'b0, 8'h00, 32'h0,         32'h0000_007E, 1'b0};
    vt[8]  = '{1'b1, 8'h04, 32'hFFFF_ABCD, 32'h0,         1'b0};
    vt[9]  = '{1'b0, 8'h04, 32'h0,         32'h0000_ABCD, 1'b0};
    vt[10] = '{1'b1, 8'h24, 32'h0000_0001, 32'h0,         1'b1};
    vt[11] = '{1'b1, 8'h00, 32'h0,         32'h0,         1'b0};
    vt[12] = '{1'b0, 8'h00, 32'h0,         32'h0000_0000, 1'b0};
    vt[13] = '{1'b0, 8'h0C, 32'h0,         32'h0000_0000, 1'b0};
    vt[14] = '{1'b0, 8'h08, 32'h0,         32'h0000_0005, 1'b0};

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    check("reset ss_n", {28'b0, ss_n}, 32'hF);
    check("reset sclk", {31'b0, sclk}, 32'h0);
    check("reset mosi", {31'b0, mosi}, 32'h0);
    check("reset PRDATA", PRDATA, 32'h0);
    check("reset PSLVERR", {31'b0, PSLVERR}, 32'h0);
    check("PREADY", {31'b0, PREADY}, 32'h1);

    for (int i = 0; i < 15; i++) begin
      if (vt[i].wr) begin
        apb_wr(vt[i].addr, vt[i].wdata, e);
        check($sformatf("vec%0d wr err", i), {31'b0, e}, {31'b0, vt[i].exp_err});
      end else begin
        apb_rd(vt[i].addr, d, e);
        check($sformatf("vec%0d rd data", i), d, vt[i].exp_rd);
        check($sformatf("vec%0d rd err", i), {31'b0, e}, {31'b0, vt[i].exp_err});
      end
    end

    // Mode 0, MSB first, DIV=1, SS_SEL=2
    wr(8'h04, 32'd1);
    wr(8'h00, 32'h21);
    wr(8'h0C, 32'hA5);
    capture(8, 4, seq, bp, ssat, to);
    check("m0 timeout", {31'b0, to}, 32'h0);
    check("m0 mosi seq", seq & 32'hFF, 32'hA5);
    check("m0 sclk period", bp, 0);
    check("m0 ss_n", {28'b0, ssat}, 32'hB);
    wait_ss(1'b1, 100, "m0 end");
    rd_check("m0 status", 8'h08, 32'h01);
    rd_check("m0 rxdata", 8'h10, 32'hA5);
    rd_check("m0 status empty", 8'h08, 32'h05);

    // Mode 3, LSB first
    wr(8'h00, 32'h2F);
    repeat (2) begin @(posedge PCLK); #1; end
    check("m3 sclk idle", {31'b0, sclk}, 32'h1);
    wr(8'h0C, 32'h3C);
    capture(8, 4, seq, bp, ssat, to);
    check("m3 timeout", {31'b0, to}, 32'h0);
    check("m3 mosi seq", seq & 32'hFF, 32'h3C);
    check("m3 ss_n", {28'b0, ssat}, 32'hB);
    wait_ss(1'b1, 100, "m3 end");
    check("m3 sclk after", {31'b0, sclk}, 32'h1);
    rd_check("m3 rxdata", 8'h10, 32'h3C);

    // Three queued frames run back to back under one select
    wr(8'h04, 32'd0);
    wr(8'h00, 32'h20);
    wr(8'h0C, 32'h11);
    wr(8'h0C, 32'h22);
    wr(8'h0C, 32'h33);
    wr(8'h00, 32'h21);
    wait_ss(1'b0, 20, "b2b start");
    rises = 0; ssbad = 0; c = 0;
    prev = sclk;
    while (ss_n != 4'hF && c < 300) begin
      @(posedge PCLK); #1;
      c++;
      if (!prev && sclk) rises++;
      if (ss_n != 4'hF && ss_n != 4'hB) ssbad++;
      prev = sclk;
    end
    check("b2b sclk rises", rises, 24);
    check("b2b ss glitches", ssbad, 0);
    rd_check("b2b status", 8'h08, 32'h01);
    rd_check("b2b rx0", 8'h10, 32'h11);
    rd_check("b2b rx1", 8'h10, 32'h22);
    rd_check("b2b rx2", 8'h10, 32'h33);
    rd_check("b2b status empty", 8'h08, 32'h05);

    // Nine frames into an eight-deep RX FIFO
    for (int i = 0; i < 9; i++) begin
      wr(8'h0C, 32'h40 + i);
      wait_ss(1'b0, 20, $sformatf("ovf start %0d", i));
      wait_ss(1'b1, 100, $sformatf("ovf end %0d", i));
    end
    rd_check("ovf status", 8'h08, 32'h29);
    wr(8'h08, 32'h20);
    rd_check("ovf cleared", 8'h08, 32'h09);
    for (int i = 0; i < 8; i++) rd_check($sformatf("ovf rx%0d", i), 8'h10, 32'h40 + i);
    rd_check("ovf drained", 8'h08, 32'h05);

    // TX full drop, then reset in the middle of a frame
    wr(8'h00, 32'h20);
    for (int i = 0; i < 9; i++) wr(8'h0C, 32'h50 + i);
    rd_check("tx full status", 8'h08, 32'h06);
    wr(8'h04, 32'd3);
    wr(8'h00, 32'h21);
    rises = 0; c = 0;
    prev = sclk;
    while (rises < 3 && c < 300) begin
      @(posedge PCLK); #1;
      c++;
      if (!prev && sclk) rises++;
      prev = sclk;
    end
    check("rst mid rises", rises, 3);
    check("rst mid ss low", {28'b0, ss_n}, 32'hB);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("rst ss_n", {28'b0, ss_n}, 32'hF);
    check("rst sclk", {31'b0, sclk}, 32'h0);
    check("rst mosi", {31'b0, mosi}, 32'h0);
    PRESET = 1'b0;
    rd_check("rst status", 8'h08, 32'h05);
    rd_check("rst ctrl", 8'h00, 32'h00);
    rd_check("rst rxdata", 8'h10, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
